// File: rtl/router_xy_credit.sv
// 5-port wormhole NoC router (port order E, W, N, S, LOCAL): per-input FIFOs, XY routing,
// per-output round-robin arbitration with wormhole locking, and credit flow control.
module router_xy_credit #(
    parameter int         FLIT_WIDTH   = 16,
    parameter int         BUFFER_DEPTH = 4,
    parameter logic [7:0] ADDRESS      = 8'h00
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4:0]              rx,
    input  logic [5*FLIT_WIDTH-1:0] data_i,
    output logic [4:0]              credit_o,
    output logic [4:0]              tx,
    output logic [5*FLIT_WIDTH-1:0] data_o,
    input  logic [4:0]              credit_i
);
    localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [2:0] P_EAST  = 3'd0;
    localparam logic [2:0] P_WEST  = 3'd1;
    localparam logic [2:0] P_NORTH = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_LOCAL = 3'd4;

    typedef enum logic [1:0] {IDLE, ROUTE, SIZE, PAYLOAD} in_state_t;

    logic [FLIT_WIDTH-1:0] head [5];
    logic [2:0]            route [5];
    logic [2:0]            grant_idx [5];
    logic [4:0]            not_empty;
    logic [4:0]            req_valid;
    logic [4:0]            release_flit;
    logic [4:0]            pop;

    genvar gi;

    for (gi = 0; gi < 5; gi++) begin : g_in
        logic [FLIT_WIDTH-1:0] mem_reg [BUFFER_DEPTH];
        logic [PW-1:0]         wr_ptr_reg;
        logic [PW-1:0]         rd_ptr_reg;
        logic [CW-1:0]         count_reg;
        logic [FLIT_WIDTH-1:0] cnt_reg, cnt_next;
        in_state_t             state_reg, state_next;
        logic                  wr_en;
        logic                  req_local, rel_local;
        logic [3:0]            hdr_x, hdr_y;

        assign credit_o[gi]  = (count_reg != CW'(BUFFER_DEPTH)) && !reset;
        assign wr_en         = rx[gi] && credit_o[gi];
        assign not_empty[gi] = (count_reg != '0);
        assign head[gi]      = mem_reg[rd_ptr_reg];

        always_ff @(posedge clock) begin
            if (wr_en)
                mem_reg[wr_ptr_reg] <= data_i[gi*FLIT_WIDTH +: FLIT_WIDTH];
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (wr_en)
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop[gi])
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                if (wr_en && !pop[gi])
                    count_reg <= count_reg + CW'(1);
                else if (!wr_en && pop[gi])
                    count_reg <= count_reg - CW'(1);
            end
        end

        // Route is only meaningful while the head flit is a header (IDLE/ROUTE).
        assign hdr_x = head[gi][7:4];
        assign hdr_y = head[gi][3:0];
        assign route[gi] = (hdr_x > ADDRESS[7:4]) ? P_EAST  :
                           (hdr_x < ADDRESS[7:4]) ? P_WEST  :
                           (hdr_y > ADDRESS[3:0]) ? P_NORTH :
                           (hdr_y < ADDRESS[3:0]) ? P_SOUTH : P_LOCAL;

        always_ff @(posedge clock) begin
            if (reset) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            case (state_reg)
                IDLE:    if (not_empty[gi]) state_next = ROUTE;
                ROUTE:   if (pop[gi]) state_next = SIZE;
                SIZE: begin
                    if (pop[gi]) begin
                        cnt_next   = head[gi];
                        state_next = (head[gi] == '0) ? IDLE : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pop[gi]) begin
                        cnt_next = cnt_reg - FLIT_WIDTH'(1);
                        if (cnt_reg == FLIT_WIDTH'(1))
                            state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // Requesting already in IDLE lets a header arbitrate the cycle it becomes visible.
        always_comb begin
            req_local = 1'b0;
            rel_local = 1'b0;
            case (state_reg)
                IDLE, ROUTE: req_local = not_empty[gi];
                SIZE:        rel_local = pop[gi] && (head[gi] == '0);
                PAYLOAD:     rel_local = pop[gi] && (cnt_reg == FLIT_WIDTH'(1));
                default:     ;
            endcase
        end

        assign req_valid[gi]    = req_local;
        assign release_flit[gi] = rel_local;

        a_no_overrun: assert property (@(posedge clock) disable iff (reset)
            !(rx[gi] && !credit_o[gi]));
    end

    // An input owns at most one output, so any tx naming it as grantee pops its FIFO.
    always_comb begin
        pop = '0;
        for (int i = 0; i < 5; i++)
            for (int o = 0; o < 5; o++)
                if (tx[o] && (grant_idx[o] == 3'(i)))
                    pop[i] = 1'b1;
    end

    for (gi = 0; gi < 5; gi++) begin : g_out
        logic       gv_reg;
        logic [2:0] gidx_reg, ptr_reg, winner, rr_idx;
        logic [3:0] rr_sum;
        logic [4:0] req_vec;
        logic       found, release_out;

        always_comb begin
            req_vec = '0;
            for (int i = 0; i < 5; i++)
                req_vec[i] = req_valid[i] && (route[i] == 3'(gi));
        end

        always_comb begin
            found  = 1'b0;
            winner = '0;
            rr_idx = '0;
            rr_sum = '0;
            for (int k = 0; k < 5; k++) begin
                rr_sum = {1'b0, ptr_reg} + 4'(k);
                rr_idx = (rr_sum >= 4'd5) ? 3'(rr_sum - 4'd5) : rr_sum[2:0];
                if (!found && req_vec[rr_idx]) begin
                    found  = 1'b1;
                    winner = rr_idx;
                end
            end
        end

        assign release_out = gv_reg && release_flit[gidx_reg];

        // The lock holds until the release flit leaves; arbitration resumes next cycle.
        always_ff @(posedge clock) begin
            if (reset) begin
                gv_reg   <= 1'b0;
                gidx_reg <= '0;
                ptr_reg  <= '0;
            end else if (gv_reg) begin
                if (release_out)
                    gv_reg <= 1'b0;
            end else if (found) begin
                gv_reg   <= 1'b1;
                gidx_reg <= winner;
                ptr_reg  <= (winner == 3'd4) ? 3'd0 : winner + 3'd1;
            end
        end

        assign grant_idx[gi] = gidx_reg;
        assign tx[gi] = gv_reg && not_empty[gidx_reg] && credit_i[gi] && !reset;
        assign data_o[gi*FLIT_WIDTH +: FLIT_WIDTH] = tx[gi] ? head[gidx_reg] : '0;
    end
endmodule

// File: tb/tb_router_xy_credit.sv
// Directed bench for router_xy_credit at ADDRESS 8'h11: latency, loopback, arbitration order,
// backpressure, mid-packet reset and concurrent disjoint routes, with hand-computed flit streams.
module tb_router_xy_credit;
    localparam int FW = 16;

    logic          clock;
    logic          reset;
    logic [4:0]    rx, credit_o, tx, credit_i;
    logic [5*FW-1:0] data_i, data_o;

    router_xy_credit #(
        .FLIT_WIDTH  (FW),
        .BUFFER_DEPTH(4),
        .ADDRESS     (8'h11)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rx      (rx),
        .data_i  (data_i),
        .credit_o(credit_o),
        .tx      (tx),
        .data_o  (data_o),
        .credit_i(credit_i)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;
    int cyc = 0;

    logic [FW-1:0] send_q   [5][$];
    int            sent_cyc [5][$];
    logic [FW-1:0] out_data [5][$];
    int            out_cyc  [5][$];
    int            credit_low [5];
    logic [FW-1:0] exp_q [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks_cnt++;
        if (got !== expv) begin
            errors_cnt++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic clear_logs();
        for (int p = 0; p < 5; p++) begin
            sent_cyc[p].delete();
            out_data[p].delete();
            out_cyc[p].delete();
            credit_low[p] = 0;
        end
    endtask

    function automatic int others(input int o);
        int s = 0;
        for (int p = 0; p < 5; p++)
            if (p != o) s += out_data[p].size();
        return s;
    endfunction

    // Feeder: one flit per cycle per input, only while that input shows credit.
    initial begin
        rx = '0;
        data_i = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int p = 0; p < 5; p++) begin
                if (send_q[p].size() > 0 && credit_o[p]) begin
                    rx[p] = 1'b1;
                    data_i[p*FW +: FW] = send_q[p].pop_front();
                    sent_cyc[p].push_back(cyc);
                end else begin
                    rx[p] = 1'b0;
                    data_i[p*FW +: FW] = '0;
                end
            end
        end
    end

    // Monitor: log every delivered flit with its cycle, and count low-credit cycles.
    initial begin
        forever begin
            @(negedge clock);
            for (int o = 0; o < 5; o++) begin
                if (tx[o]) begin
                    out_data[o].push_back(data_o[o*FW +: FW]);
                    out_cyc[o].push_back(cyc);
                end
                if (!reset && !credit_o[o])
                    credit_low[o]++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_out(input string tag, input int o, input int n, input int budget);
        int waited = 0;
        while (out_data[o].size() < n && waited < budget) begin
            @(posedge clock);
            waited++;
        end
        if (waited >= budget)
            check_eq({tag, "_timeout"}, 32'(out_data[o].size()), 32'(n));
    endtask

    task automatic check_out(input string tag, input int o);
        $display("%s: port %0d delivered %0d flits", tag, o, out_data[o].size());
        check_eq({tag, "_len"}, 32'(out_data[o].size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < out_data[o].size(); k++)
            check_eq($sformatf("%s_flit%0d", tag, k), 32'(out_data[o][k]), 32'(exp_q[k]));
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        for (int p = 0; p < 5; p++) send_q[p].delete();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        reset    = 1'b1;
        credit_i = 5'h1f;
        clear_logs();

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_tx", 32'(tx), 32'h0);
        check_eq("rst_data_nonzero", 32'(data_o != '0), 32'h0);
        check_eq("rst_credit", 32'(credit_o), 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_credit_up", 32'(credit_o), 32'h1f);
        clear_logs();

        // T1: LOCAL -> EAST, header out at t+2 then one flit per cycle
        send_q[4] = {16'h0031, 16'h0002, 16'hA001, 16'hA002};
        wait_out("t1", 0, 4, 40);
        exp_q = {16'h0031, 16'h0002, 16'hA001, 16'hA002};
        check_out("t1_east", 0);
        for (int k = 0; k < 4 && k < out_cyc[0].size(); k++)
            check_eq($sformatf("t1_cyc%0d", k), 32'(out_cyc[0][k]), 32'(sent_cyc[4][0] + 2 + k));
        check_eq("t1_credit_low", 32'(credit_low[4]), 32'h0);
        check_eq("t1_other_ports", 32'(others(0)), 32'h0);

        // T2: WEST -> LOCAL, two zero-length packets back to back
        do_reset();
        send_q[1] = {16'h0011, 16'h0000, 16'h0011, 16'h0000};
        wait_out("t2", 4, 4, 40);
        exp_q = {16'h0011, 16'h0000, 16'h0011, 16'h0000};
        check_out("t2_local", 4);
        if (out_cyc[4].size() >= 4) begin
            check_eq("t2_hdr_cyc", 32'(out_cyc[4][0]), 32'(sent_cyc[1][0] + 2));
            check_eq("t2_rel_cyc", 32'(out_cyc[4][1]), 32'(out_cyc[4][0] + 1));
            check_eq("t2_regrant_cyc", 32'(out_cyc[4][2]), 32'(out_cyc[4][1] + 2));
        end

        // T3: E, W, N all to LOCAL at once; round-robin from ptr 0
        do_reset();
        send_q[0] = {16'h0011, 16'h0001, 16'hE0E0};
        send_q[1] = {16'h0011, 16'h0001, 16'hB0B0};
        send_q[2] = {16'h0011, 16'h0001, 16'hC0C0};
        wait_out("t3", 4, 9, 60);
        exp_q = {16'h0011, 16'h0001, 16'hE0E0,
                 16'h0011, 16'h0001, 16'hB0B0,
                 16'h0011, 16'h0001, 16'hC0C0};
        check_out("t3_local", 4);
        if (out_cyc[4].size() >= 9) begin
            check_eq("t3_first_hdr_cyc", 32'(out_cyc[4][0]), 32'(sent_cyc[0][0] + 2));
            check_eq("t3_second_hdr_cyc", 32'(out_cyc[4][3]), 32'(out_cyc[4][2] + 2));
        end

        // T4: EAST blocked, 6 flits offered into a 4-deep FIFO
        do_reset();
        credit_i = 5'b11110;
        send_q[4] = {16'h0031, 16'h0004, 16'hD001, 16'hD002, 16'hD003, 16'hD004};
        repeat (10) @(posedge clock);
        check_eq("t4_written", 32'(sent_cyc[4].size()), 32'd4);
        check_eq("t4_pending", 32'(send_q[4].size()), 32'd2);
        check_eq("t4_no_tx", 32'(out_data[0].size()), 32'd0);
        @(negedge clock);
        check_eq("t4_credit_low", 32'(credit_o[4]), 32'h0);
        check_eq("t4_tx_blocked", 32'(tx), 32'h0);
        @(posedge clock);
        #2;
        credit_i = 5'h1f;
        wait_out("t4", 0, 6, 40);
        exp_q = {16'h0031, 16'h0004, 16'hD001, 16'hD002, 16'hD003, 16'hD004};
        check_out("t4_east", 0);

        // T5: reset in the middle of a payload, then a fresh NORTH -> SOUTH packet
        do_reset();
        send_q[4] = {16'h0031, 16'h0006, 16'h7001, 16'h7002, 16'h7003,
                     16'h7004, 16'h7005, 16'h7006};
        wait_out("t5_mid", 0, 4, 40);
        @(posedge clock);
        #2;
        reset = 1'b1;
        for (int p = 0; p < 5; p++) send_q[p].delete();
        @(posedge clock);
        @(negedge clock);
        check_eq("t5_rst_tx", 32'(tx), 32'h0);
        check_eq("t5_rst_credit", 32'(credit_o), 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        check_eq("t5_credit_back", 32'(credit_o), 32'h1f);
        clear_logs();
        send_q[2] = {16'h0010, 16'h0001, 16'h5A5A};
        wait_out("t5", 3, 3, 40);
        repeat (10) @(posedge clock);
        exp_q = {16'h0010, 16'h0001, 16'h5A5A};
        check_out("t5_south", 3);
        check_eq("t5_no_stale", 32'(others(3)), 32'h0);

        // T6: five disjoint routes at once, EAST blocked without stalling the rest
        do_reset();
        credit_i = 5'b11110;
        send_q[4] = {16'h0031, 16'h0002, 16'h4A01, 16'h4A02};
        send_q[0] = {16'h0001, 16'h0002, 16'h0A01, 16'h0A02};
        send_q[1] = {16'h0012, 16'h0002, 16'h1A01, 16'h1A02};
        send_q[2] = {16'h0010, 16'h0002, 16'h2A01, 16'h2A02};
        send_q[3] = {16'h0011, 16'h0002, 16'h3A01, 16'h3A02};
        for (int o = 1; o < 5; o++)
            wait_out($sformatf("t6_out%0d", o), o, 4, 40);
        exp_q = {16'h0001, 16'h0002, 16'h0A01, 16'h0A02};
        check_out("t6_west", 1);
        exp_q = {16'h0012, 16'h0002, 16'h1A01, 16'h1A02};
        check_out("t6_north", 2);
        exp_q = {16'h0010, 16'h0002, 16'h2A01, 16'h2A02};
        check_out("t6_south", 3);
        exp_q = {16'h0011, 16'h0002, 16'h3A01, 16'h3A02};
        check_out("t6_local", 4);
        for (int o = 1; o < 5; o++)
            if (out_cyc[o].size() > 0)
                check_eq($sformatf("t6_hdr_cyc%0d", o), 32'(out_cyc[o][0]),
                         32'(sent_cyc[o - 1][0] + 2));
        check_eq("t6_east_blocked", 32'(out_data[0].size()), 32'd0);
        @(posedge clock);
        #2;
        credit_i = 5'h1f;
        wait_out("t6_east", 0, 4, 40);
        exp_q = {16'h0031, 16'h0002, 16'h4A01, 16'h4A02};
        check_out("t6_east", 0);

        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
